// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES-128 key expansion. A start pulse in IDLE captures key_in as
//   round key 0; each accepted rk_valid/rk_ready transfer advances to the next
//   round key, up to round 10. After the round-10 key is accepted, done
//   pulses for one cycle and the engine returns to IDLE.
//
//   Optional feature (macro ROUND_KEY_CACHE_EN): an 11-entry round-key buffer
//   with a registered read port (rd_idx -> rd_key, 1-cycle latency), so the
//   decryption path can walk the keys in reverse order. Without the macro,
//   rd_key is tied to zero and rd_idx is ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   start      expansion request, sampled only in IDLE
//   key_in     128-bit cipher key, key_in[127:120] is byte 0 (w0 = [127:96])
//   rk_valid   round_key / rk_round are valid
//   rk_ready   consumer accepts the current round key
//   round_key  current round key, same byte order as key_in
//   rk_round   round index of round_key, 0..10
//   busy       high from the cycle after start until round 10 is accepted
//   done       one-cycle pulse after the round-10 key is accepted
//   rd_idx     cache read index
//   rd_key     cached round key for rd_idx (zero for rd_idx > 10)
// ---------------------------------------------------------------------------

// Combinational AES byte S-box: multiplicative inverse in GF(2^8) followed by
// the FIPS-197 affine transform.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    // Built as x^2 * x^4 * ... * x^128 by repeated squaring.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv     = gf_inv(byte_val);
        sub_val = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

module aes_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [7:0]   rcon;
    logic [7:0]   rcon_next;
    logic [127:0] round_key_next;
    logic [3:0]   rk_round_next;
    logic         rk_valid_next;
    logic         busy_next;
    logic         done_next;
    logic         key_load;

    // -----------------------------------------------------------------------
    // Next round key from the current one
    // -----------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  t;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    assign w0     = round_key[127:96];
    assign w1     = round_key[95:64];
    assign w2     = round_key[63:32];
    assign w3     = round_key[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sbox u_sbox0 (.byte_val(rot_w3[31:24]), .sub_val(sub_w3[31:24]));
    aes_sbox u_sbox1 (.byte_val(rot_w3[23:16]), .sub_val(sub_w3[23:16]));
    aes_sbox u_sbox2 (.byte_val(rot_w3[15:8]),  .sub_val(sub_w3[15:8]));
    aes_sbox u_sbox3 (.byte_val(rot_w3[7:0]),   .sub_val(sub_w3[7:0]));

    assign t        = sub_w3 ^ {rcon, 24'h000000};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            round_key <= '0;
            rk_round  <= '0;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rcon      <= 8'h01;
        end else begin
            state     <= state_next;
            round_key <= round_key_next;
            rk_round  <= rk_round_next;
            rk_valid  <= rk_valid_next;
            busy      <= busy_next;
            done      <= done_next;
            rcon      <= rcon_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so
    // rk_ready only influences the next edge.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        round_key_next = round_key;
        rk_round_next  = rk_round;
        rk_valid_next  = rk_valid;
        busy_next      = busy;
        done_next      = 1'b0;
        rcon_next      = rcon;
        key_load       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    round_key_next = key_in;
                    rk_round_next  = '0;
                    rk_valid_next  = 1'b1;
                    busy_next      = 1'b1;
                    rcon_next      = 8'h01;
                    key_load       = 1'b1;
                    state_next     = EMIT;
                end
            end

            EMIT: begin
                if (rk_valid && rk_ready) begin
                    if (rk_round < LAST_ROUND) begin
                        round_key_next = next_key;
                        rk_round_next  = rk_round + 4'd1;
                        rcon_next      = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        key_load       = 1'b1;
                    end else begin
                        rk_valid_next  = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                        state_next     = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Optional round-key cache
    // -----------------------------------------------------------------------
`ifdef ROUND_KEY_CACHE_EN
    logic [127:0] cache [0:10];

    // Each entry is written on the edge where that round key becomes valid,
    // i.e. at the index and data the output registers are about to load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache  <= '{default: '0};
            rd_key <= '0;
        end else begin
            if (key_load) begin
                cache[rk_round_next] <= round_key_next;
            end
            if (rd_idx <= LAST_ROUND) begin
                rd_key <= cache[rd_idx];
            end else begin
                rd_key <= '0;
            end
        end
    end
`else
    logic unused_cache_sigs;

    assign rd_key            = '0;
    assign unused_cache_sigs = ^{rd_idx, key_load};
`endif

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES-128 key expansion engine.
- Loads a 128-bit cipher key and emits round keys 0..10 in order, one per accepted transfer, over a valid/ready handshake.
- Sits directly upstream of the AddRoundKey stage and supplies its key input for every round of encryption.
- Optionally keeps all 11 round keys in an indexed buffer so decryption can read them in reverse order.

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128, and no other value is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- start  input  1  pulse that requests expansion of key_in; sampled only in IDLE
- key_in  input  128  cipher key; key_in[127:120] is byte 0, and w0 = key_in[127:96]
- rk_valid  output  1  round_key / rk_round are valid
- rk_ready  input  1  consumer accepts the current round key
- round_key  output  128  current round key, same byte order as key_in
- rk_round  output  4  index of round_key, 0..10
- busy  output  1  high from the cycle after start until the round-10 key is accepted
- done  output  1  one-cycle pulse on the cycle after the round-10 key is accepted
- rd_idx  input  4  cache read index (ROUND_KEY_CACHE_EN only)
- rd_key  output  128  cached round key rd_idx (ROUND_KEY_CACHE_EN only)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a clk edge):
  - State becomes IDLE.
  - round_key, rk_round, rk_valid, busy, done and rd_key all clear to 0.
  - Round counter clears to 0; rcon register loads 8'h01.
  - Reset mid-expansion aborts immediately with no partial done.
- States: IDLE, EMIT, DONE.
- IDLE:
  - On start=1: latch key_in into round_key, set rk_round=0, rk_valid=1, busy=1, go to EMIT.
  - On start=0: remain in IDLE.
- EMIT:
  - Transfer occurs on the cycle where rk_valid && rk_ready.
  - With rk_round<10: on the next edge round_key <= next key, rk_round += 1, rcon <= xtime(rcon); rk_valid stays 1. Back-to-back transfers therefore run at one key per cycle.
  - With rk_round==10: on the next edge rk_valid=0, busy=0, done=1, go to DONE.
  - No transfer (rk_ready=0): round_key, rk_round and rcon hold stable; no combinational dependence on rk_ready.
- DONE: done=1 for exactly one cycle, then go to IDLE; round_key keeps the round-10 key.
- Next-key arithmetic (per FIPS-197):
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - SubWord uses four instances of the team's combinational byte S-box.
  - xtime: shift left by one; if the input MSB was 1, XOR with 8'h1B.
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Latency: round 0 key is valid 1 cycle after start; with rk_ready tied high, round k is valid at cycle 1+k and done pulses at cycle 12.
- start while busy or in DONE: ignored; no restart and no key_in capture.
- key_in changing after the start cycle: no effect.
- start and reset deasserting on the same edge: reset wins; start is ignored that cycle.

Optional Feature:
- Macro: ROUND_KEY_CACHE_EN.
- Defined:
  - An 11 x 128 register array stores each round key when it is first presented: entry rk_round is written on the edge where it becomes valid.
  - rd_key is a registered read of entry rd_idx with 1-cycle latency.
  - rd_idx > 10 returns 128'd0.
  - Entries persist through DONE and IDLE until overwritten by the next start; reset clears the whole array.
- Undefined: no array; rd_key is tied to 128'd0 and rd_idx is unused.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start pulse:
  - round 0 equals key_in;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 11;
  - done pulses at cycle 12.
- Same key, rk_ready low for 3 cycles at round 4: round_key and rk_round stay at 4 for all stalled cycles; subsequent keys are still correct; done occurs 3 cycles later than the no-stall run.
- All-zero key: round 1 = 62636363626363636263636362636363 and round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed again at round 6 with a different key_in: ignored; the original sequence completes unchanged.
- rst=0 asserted at round 5: the next cycle shows rk_valid=0, busy=0, round_key=0; a new start restarts from round 0 and produces correct values.
- ROUND_KEY_CACHE_EN, after the FIPS-197 run: rd_idx=10 gives d014f9a8…0ca6 one cycle later; rd_idx=0 gives 2b7e…4f3c; rd_idx=15 gives 0.
